// File: rtl/mux8way_pkt_arbiter_pkg.sv
// Shared constants, FSM state encoding and helpers for the 8-way packet arbiter.
// Imported by the interface, the round-robin picker and the top level.
`ifndef MUX8WAY_PKT_ARBITER_PKG_SV
`define MUX8WAY_PKT_ARBITER_PKG_SV

package mux8way_pkt_arbiter_pkg;

    localparam int N_CH   = 8;
    localparam int SEL_W  = 3;
    localparam int WORD_W = 16;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_e;

    function automatic logic [N_CH-1:0] onehot8(input logic [SEL_W-1:0] idx);
        return N_CH'(1) << idx;
    endfunction

endpackage

`endif

// File: rtl/mux8way_pkt_arbiter_if.sv
// Bundle of the eight producer channels and the single consumer channel.
// The arbiter uses the slave view; the producer/consumer side uses master.
interface mux8way_pkt_arbiter_if #(
    parameter int WIDTH = mux8way_pkt_arbiter_pkg::WORD_W
);
    import mux8way_pkt_arbiter_pkg::*;

    logic [N_CH-1:0]       in_valid;
    logic [N_CH-1:0]       in_last;
    logic [N_CH*WIDTH-1:0] in_data;
    logic [N_CH-1:0]       in_ready;
    logic                  out_valid;
    logic                  out_ready;
    logic                  out_last;
    logic [WIDTH-1:0]      out_data;
    logic [SEL_W-1:0]      out_sel;

    modport slave (
        input  in_valid, in_last, in_data, out_ready,
        output in_ready, out_valid, out_last, out_data, out_sel
    );

    modport master (
        output in_valid, in_last, in_data, out_ready,
        input  in_ready, out_valid, out_last, out_data, out_sel
    );

endinterface

// File: rtl/mux8way_pkt_arbiter_rr_pick8.sv
// Combinational round-robin picker: first requester after ptr_i, wrapping mod 8.
// Rotates the request vector, priority-encodes the lowest bit, rotates back.
module mux8way_pkt_arbiter_rr_pick8
    import mux8way_pkt_arbiter_pkg::*;
(
    input  logic [N_CH-1:0]  req_i,
    input  logic [SEL_W-1:0] ptr_i,
    output logic [N_CH-1:0]  grant_o,
    output logic [SEL_W-1:0] idx_o
);

    logic [SEL_W-1:0]  start;
    logic [2*N_CH-1:0] dbl;
    logic [N_CH-1:0]   rot;
    logic [SEL_W-1:0]  off;
    logic              any;

    assign start = ptr_i + SEL_W'(1);

    // Bit i of rot is the request of channel (start + i) mod 8.
    always_comb begin
        dbl = {req_i, req_i} >> start;
        rot = dbl[N_CH-1:0];
        off = '0;
        any = 1'b0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = SEL_W'(i);
                any = 1'b1;
            end
        end
        idx_o   = start + off;
        grant_o = any ? onehot8(idx_o) : '0;
    end

endmodule

// File: rtl/mux8way_pkt_arbiter.sv
// Merges eight valid/ready channels into one registered output channel using
// round-robin arbitration that stays locked on a channel until its last beat.
module mux8way_pkt_arbiter
    import mux8way_pkt_arbiter_pkg::*;
#(
    parameter int WIDTH = WORD_W,
    parameter int N     = N_CH
) (
    input  logic                  clk,
    input  logic                  reset,
    mux8way_pkt_arbiter_if.slave  bus
);

    arb_state_e       state_q;
    logic [SEL_W-1:0] cur_q;
    logic [SEL_W-1:0] rr_q;

    logic             out_valid_q;
    logic             out_last_q;
    logic [WIDTH-1:0] out_data_q;
    logic [SEL_W-1:0] out_sel_q;

    logic [N-1:0]     pick_grant;
    logic [SEL_W-1:0] pick_idx;
    logic [N-1:0]     grant;
    logic [N-1:0]     ready;
    logic [SEL_W-1:0] sel;
    logic [WIDTH-1:0] sel_data;
    logic             sel_last;
    logic             load;
    logic             xfer;

    mux8way_pkt_arbiter_rr_pick8 u_pick (
        .req_i   (bus.in_valid),
        .ptr_i   (rr_q),
        .grant_o (pick_grant),
        .idx_o   (pick_idx)
    );

    // The output register can take a new beat when empty or draining this cycle.
    assign load = ~out_valid_q | bus.out_ready;

    // While locked, only the owning channel may be granted; a gap there is a bubble.
    always_comb begin
        grant = '0;
        sel   = pick_idx;
        if (state_q == ST_IDLE) begin
            grant = pick_grant;
        end else begin
            sel = cur_q;
            if (bus.in_valid[cur_q]) begin
                grant = onehot8(cur_q);
            end
        end
    end

    assign ready    = load ? grant : '0;
    assign xfer     = |ready;
    assign sel_data = bus.in_data[sel*WIDTH +: WIDTH];
    assign sel_last = bus.in_last[sel];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cur_q       <= '0;
            rr_q        <= SEL_W'(N - 1);
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
        end else if (xfer) begin
            out_valid_q <= 1'b1;
            out_last_q  <= sel_last;
            out_data_q  <= sel_data;
            out_sel_q   <= sel;
            // Pointer advances only when a packet closes, so fairness is per packet.
            if (sel_last) begin
                state_q <= ST_IDLE;
                rr_q    <= sel;
            end else begin
                state_q <= ST_LOCKED;
                cur_q   <= sel;
            end
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.in_ready  = ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_sel   = out_sel_q;

endmodule

// File: doc/mux8way_pkt_arbiter.md
Name: mux8way_pkt_arbiter

Overview:
- Collecting counterpart of the 8-way demultiplexer: merges eight 16-bit valid/ready input channels into one output channel.
- Round-robin arbitration with packet locking: once a channel is granted, it keeps the grant until its last beat is accepted.
- Output is registered through a single-entry output stage, so sustained throughput is one beat per cycle.
- Sits in front of a shared consumer, e.g. a memory-write port or serial transmitter fed by eight producers.

Parameters:
- WIDTH, 16, data width per channel (Hack word).
- N, 8, number of input channels; fixed at 8, sel width is 3.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  8  per-channel beat valid; bit k is channel k.
- in_last  input  8  per-channel end-of-packet marker, qualified by in_valid.
- in_data  input  8*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
- in_ready  output  8  per-channel accept, one-hot or zero.
- out_valid  output  1  output register holds a beat.
- out_last  output  1  registered last flag of the held beat.
- out_data  output  WIDTH  registered data.
- out_sel  output  3  index of the channel that produced the held beat.

Behaviour:
- Reset, asynchronous:
  - out_valid=0, out_last=0, out_data=0, out_sel=0.
  - state=IDLE, cur=0, rr_ptr=7, so channel 0 has first priority.
- Handshakes:
  - Input transfer on channel k: in_valid[k] & in_ready[k] at a rising edge.
  - Output transfer: out_valid & out_ready.
- load = ~out_valid | out_ready. This is the output register free condition, combinational from out_ready.
- in_ready is combinational: in_ready[k] = load & grant[k]. At most one bit is set; in_ready never depends on in_data.
- FSM states:
  - IDLE: no packet open.
    - grant = first k with in_valid[k]=1, searching k = rr_ptr+1, rr_ptr+2, … mod 8.
    - No valid channel → grant=0.
  - LOCKED: packet open on channel cur.
    - grant = one-hot(cur) when in_valid[cur]=1, else 0.
    - Other channels are ignored even if valid.
- On input transfer from channel k:
  - out_data <= in_data[k], out_last <= in_last[k], out_sel <= k, out_valid <= 1.
  - If in_last[k]=1: state <= IDLE, rr_ptr <= k.
  - Else: state <= LOCKED, cur <= k.
  - A single-beat packet (last on first beat) never enters LOCKED.
- Output side:
  - On output transfer with no simultaneous input transfer: out_valid <= 0.
  - out_data, out_last and out_sel hold their last values while out_valid=0.
- Simultaneous output and input transfer in the same cycle: register is replaced, out_valid stays 1 (full throughput).
- Latency: input beat appears on out_* the cycle after acceptance.
- Back-pressure: out_valid=1 & out_ready=0 → load=0.
  - All in_ready=0.
  - Output register, state, cur and rr_ptr all hold.
- LOCKED with in_valid[cur]=0: a bubble. Lock is held indefinitely; there is no timeout.
- Wrap-around: rr_ptr=7 → search starts at 0. rr_ptr=k with only channel k valid → k is granted again.
- rr_ptr updates only on a last-beat transfer, never on idle cycles.
- Reset mid-packet:
  - Output beat is dropped and the lock is released.
  - Producers must restart packets; no partial-packet recovery.
- Output stability: out_data and out_last do not change while out_valid=1 & out_ready=0.

Decomposition:
- Shared package/include:
  - Constants: N_CH=8, SEL_W=3, WORD_W=16.
  - State encodings: ST_IDLE=1'b0, ST_LOCKED=1'b1.
  - Guard macro consistent with existing include-guard style.
- Natural sub-module: rr_pick8.
  - Purely combinational.
  - Inputs: 8-bit request vector and 3-bit rr_ptr.
  - Outputs: one-hot grant and 3-bit index (rotate, priority-encode, rotate back).
- The top level holds the FSM, pointer and output register, and reuses the existing mux8way-style data select driven by the index.

Test Plan:
- Reset then all idle → out_valid=0, in_ready=8'h00, out_data=0. Then reset=1 asynchronously mid-cycle → outputs clear without a clock edge.
- All eight channels valid with single-beat packets (last=1), data=16'h0k00+k, out_ready=1 → out_sel sequence 0,1,…,7,0 one per cycle; out_data follows.
- Channel 3 sends a 4-beat packet (16'hA000..A003, last on the 4th beat) while channels 2 and 5 are valid → four consecutive beats with out_sel=3, out_last only on A003, then channel 5 next (rr after 3), then 2.
- Back-pressure: out_ready=0 for 3 cycles with out_valid=1 → out_data constant, in_ready=0. Release → transfer that cycle with new beat loaded simultaneously (out_valid stays 1).
- LOCKED on channel 6 with in_valid[6] dropped 2 cycles while channel 0 valid → in_ready[0] stays 0. Channel 6 resumes, last beat completes, then channel 0 granted.
- Wrap: only channel 7 valid with repeated single-beat packets → granted every cycle, rr_ptr stays 7, no gaps.
